// File: rtl/f16_pair_packer.sv
// Packs a valid/ready stream of F16 samples into 32-bit pairs and queues them in a
// first-word-fall-through FIFO. A flush pads an odd trailing sample. Saturated inputs are counted.
module f16_pair_packer #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             out_half,
   output logic [AW:0]      fifo_level,
   output logic [CNT_W-1:0] sat_count,
   input  logic             clr_count,
   output logic [1:0]       dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
   // ready never depends on valid, and the FIFO never accepts a push while full.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HALF  = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   state_t           r_state;
   state_t           w_next_state;
   logic [15:0]      r_hold;
   logic [32:0]      r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic [CNT_W-1:0] r_sat_count;

   logic             w_full;
   logic             w_empty;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic             w_hold_load;
   logic [32:0]      w_push_entry;
   logic [32:0]      w_head;
   logic             w_sat_in;

   assign w_full   = (r_level == LVL_FULL);
   assign w_empty  = (r_level == '0);
   assign w_accept = in_valid & in_ready;
   assign w_pop    = ~w_empty & out_ready;
   assign w_sat_in = (in_data[14:10] == 5'h1F);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (in_valid) w_next_state = flush ? S_FLUSH : S_HALF;
         end
         S_HALF: begin
            if (in_valid && !w_full) w_next_state = S_IDLE;
            else if (flush)          w_next_state = w_full ? S_FLUSH : S_IDLE;
         end
         S_FLUSH: begin
            if (!w_full) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Pair completion wins over a same-cycle flush in HALF: nothing is left to pad.
   always_comb begin
      in_ready     = 1'b0;
      w_push       = 1'b0;
      w_push_entry = '0;
      w_hold_load  = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready    = 1'b1;
            w_hold_load = in_valid;
         end
         S_HALF: begin
            in_ready = ~w_full;
            if (in_valid && !w_full) begin
               w_push       = 1'b1;
               w_push_entry = {1'b0, in_data, r_hold};
            end else if (flush && !w_full) begin
               w_push       = 1'b1;
               w_push_entry = {1'b1, 16'h0000, r_hold};
            end
         end
         S_FLUSH: begin
            if (!w_full) begin
               w_push       = 1'b1;
               w_push_entry = {1'b1, 16'h0000, r_hold};
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           r_hold <= '0;
      else if (w_hold_load) r_hold <= in_data;
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_push_entry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                      r_sat_count <= '0;
      else if (clr_count)                              r_sat_count <= '0;
      else if (w_accept && w_sat_in && !(&r_sat_count)) r_sat_count <= r_sat_count + CNT_W'(1);
   end

   assign w_head     = r_mem[r_rd_ptr];
   assign out_valid  = ~w_empty;
   assign out_data   = w_empty ? 32'h0 : w_head[31:0];
   assign out_half   = ~w_empty & w_head[32];
   assign fifo_level = r_level;
   assign sat_count  = r_sat_count;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_f16_pair_packer.sv
// Directed bench for f16_pair_packer: stimulus pushes expected words into a queue and
// a negedge monitor pops and compares every word the FIFO hands out.
module tb_f16_pair_packer;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        in_valid  = 1'b0;
   logic [15:0] in_data   = 16'h0;
   logic        flush     = 1'b0;
   logic        out_ready = 1'b0;
   logic        clr_count = 1'b0;

   logic        in_ready, out_valid, out_half;
   logic [31:0] out_data;
   logic [AW:0] fifo_level;
   logic [15:0] sat_count;
   logic [1:0]  dbg_state;

   logic        s_in_ready, s_out_valid, s_out_half;
   logic [31:0] s_out_data;
   logic [AW:0] s_fifo_level;
   logic [1:0]  s_sat_count;
   logic [1:0]  s_dbg_state;

   f16_pair_packer #(.DEPTH(DEPTH), .AW(AW), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_half(out_half), .fifo_level(fifo_level),
      .sat_count(sat_count), .clr_count(clr_count), .dbg_state(dbg_state)
   );

   f16_pair_packer #(.DEPTH(DEPTH), .AW(AW), .CNT_W(2)) u_small (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_data(s_out_data), .out_half(s_out_half), .fifo_level(s_fifo_level),
      .sat_count(s_sat_count), .clr_count(clr_count), .dbg_state(s_dbg_state)
   );

   always #5 clk = ~clk;

   logic [32:0] exp_q[$];
   logic [32:0] mon_exp;
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [15:0] m_hold = 16'h0;
   logic        m_pending = 1'b0;

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bench-side pairing model: pairs consecutive accepted samples, pads on flush.
   task automatic model_accept(input logic [15:0] d, input logic fl);
      if (m_pending) begin
         exp_q.push_back({1'b0, d, m_hold});
         m_pending = 1'b0;
      end else if (fl) begin
         exp_q.push_back({1'b1, 16'h0000, d});
      end else begin
         m_hold    = d;
         m_pending = 1'b1;
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [15:0] d, input logic fl);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      flush    = fl;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", 33'd1, 33'd0);
      else           model_accept(d, fl);
      @(posedge clk); #1;
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic pulse_flush;
      flush = 1'b1;
      if (m_pending) begin
         exp_q.push_back({1'b1, 16'h0000, m_hold});
         m_pending = 1'b0;
      end
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic pop_one;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_left"}, 33'(exp_q.size()), 33'd0);
      check({name, "_level"}, 33'(fifo_level), 33'd0);
      check({name, "_valid"}, 33'(out_valid), 33'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_word: got %h expected none", {out_half, out_data});
         end else begin
            mon_exp = exp_q.pop_front();
            check("out_word", {out_half, out_data}, mon_exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 33'(out_valid), 33'd0);
      check("rst_out_data", 33'(out_data), 33'd0);
      check("rst_out_half", 33'(out_half), 33'd0);
      check("rst_level", 33'(fifo_level), 33'd0);
      check("rst_in_ready", 33'(in_ready), 33'd1);
      check("rst_sat", 33'(sat_count), 33'd0);
      check("rst_state", 33'(dbg_state), 33'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic pair, FWFT latency and pop.
      out_ready = 1'b1;
      send(16'h3C00, 1'b0);
      send(16'hC000, 1'b0);
      check("t1_level_1", 33'(fifo_level), 33'd1);
      check("t1_valid", 33'(out_valid), 33'd1);
      check("t1_data", 33'(out_data), 33'h0C0003C00);
      @(posedge clk); #1;
      check("t1_level_0", 33'(fifo_level), 33'd0);

      // Odd sample + flush, flush with nothing pending, accept+flush from IDLE.
      send(16'h3555, 1'b0);
      pulse_flush();
      drain("t2a");
      pulse_flush();
      repeat (3) @(posedge clk);
      #1;
      check("t2_noop_valid", 33'(out_valid), 33'd0);
      check("t2_noop_state", 33'(dbg_state), 33'd0);
      send(16'h1234, 1'b1);
      drain("t2b");

      // Fill to DEPTH with a pending half, then flush into a full FIFO.
      out_ready = 1'b0;
      for (int i = 0; i < 2*DEPTH+1; i++) send(16'h1000 + 16'(i), 1'b0);
      check("t3_level_full", 33'(fifo_level), 33'(DEPTH));
      check("t3_in_ready", 33'(in_ready), 33'd0);
      check("t3_state_half", 33'(dbg_state), 33'd1);
      pulse_flush();
      check("t4_state_flush", 33'(dbg_state), 33'd2);
      check("t4_in_ready", 33'(in_ready), 33'd0);
      pop_one();
      check("t4_level_after_pop", 33'(fifo_level), 33'(DEPTH-1));
      check("t4_still_flush", 33'(dbg_state), 33'd2);
      @(posedge clk); #1;
      check("t4_level_refill", 33'(fifo_level), 33'(DEPTH));
      check("t4_state_idle", 33'(dbg_state), 33'd0);
      drain("t3");

      // Saturation counting, clear priority, narrow counter saturation.
      out_ready = 1'b1;
      send(16'h7C00, 1'b0);
      send(16'hFC00, 1'b0);
      send(16'h7E00, 1'b0);
      send(16'h3C00, 1'b0);
      check("t5_sat3", 33'(sat_count), 33'd3);
      check("t5_small_sat3", 33'(s_sat_count), 33'd3);
      clr_count = 1'b1;
      send(16'h7C00, 1'b0);
      clr_count = 1'b0;
      check("t5_clr", 33'(sat_count), 33'd0);
      check("t5_small_clr", 33'(s_sat_count), 33'd0);
      for (int i = 0; i < 5; i++) send(16'h7C00, 1'b0);
      check("t5_sat5", 33'(sat_count), 33'd5);
      check("t5_small_sat_cap", 33'(s_sat_count), 33'd3);
      drain("t5");

      // Reset in the middle of traffic.
      out_ready = 1'b0;
      for (int i = 0; i < 7; i++) send(16'h2000 + 16'(i), 1'b0);
      check("t6_level3", 33'(fifo_level), 33'd3);
      check("t6_state_half", 33'(dbg_state), 33'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 33'(out_valid), 33'd0);
      check("t6_rst_level", 33'(fifo_level), 33'd0);
      check("t6_rst_in_ready", 33'(in_ready), 33'd1);
      check("t6_rst_state", 33'(dbg_state), 33'd0);
      exp_q.delete();
      m_pending = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(16'hAAAA, 1'b0);
      send(16'hBBBB, 1'b0);
      drain("t6");
      check("t6_sat_after_rst", 33'(sat_count), 33'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
